// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths and FSM state type for the ALU arbiter.
//   OPND_W - signed operand width
//   OP_W   - opcode width
//   RES_W  - ALU result width
//   NREQ   - number of requesters
//   CNT_W  - latency counter width (covers ALU_LAT-1 for ALU_LAT up to 4)
package alu_arb_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned NREQ   = 2;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and shared-ALU signals of the ALU arbiter.
//   REQ_VALID/REQ_READY - per-requester request handshake
//   REQ_A/REQ_B/REQ_OP  - packed per-requester operands and opcodes
//   RSP_VALID/RSP_READY - per-requester response handshake
//   RSP_OUT             - shared signed result
//   ALU_A/ALU_B/ALU_OP  - operands to the shared ALU; ALU_OUT - its result
//   BUSY/GRANT_ID       - status: not idle / owner of current transaction
// Modport slave is the arbiter; master is the requester/ALU side.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ*OPND_W-1:0] REQ_A;
    logic [NREQ*OPND_W-1:0] REQ_B;
    logic [NREQ*OP_W-1:0]   REQ_OP;
    logic [NREQ-1:0]        RSP_VALID;
    logic [NREQ-1:0]        RSP_READY;
    logic [RES_W-1:0]       RSP_OUT;
    logic [OPND_W-1:0]      ALU_A;
    logic [OPND_W-1:0]      ALU_B;
    logic [OP_W-1:0]        ALU_OP;
    logic [RES_W-1:0]       ALU_OUT;
    logic                   BUSY;
    logic                   GRANT_ID;

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY, ALU_OUT,
        output REQ_READY, RSP_VALID, RSP_OUT, ALU_A, ALU_B, ALU_OP, BUSY, GRANT_ID
    );

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY, ALU_OUT,
        input  REQ_READY, RSP_VALID, RSP_OUT, ALU_A, ALU_B, ALU_OP, BUSY, GRANT_ID
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant logic (combinational).
//   valid     - request bits of the two requesters
//   last      - index of the requester served last
//   enable    - grant allowed this cycle
//   gnt_id    - index of the winner
//   gnt_valid - a winner exists and grant is enabled
// Tying last to 1 turns this into fixed priority for requester 0.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       enable,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = enable & (|valid);
        unique case (valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
//   CLK - clock; RST - synchronous active-low reset
//   bus - alu_arbiter_if.slave: request/response handshakes, shared ALU port, status
// Parameter ALU_LAT (1..4): edges from operands presented to ALU_OUT valid.
// Macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no pointer).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input logic          CLK,
    input logic          RST,
    alu_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               launch_q;
    logic               gid_q;
    logic [OPND_W-1:0]  opa_q, opb_q;
    logic [OP_W-1:0]    op_q;
    logic [RES_W-1:0]   rsp_q;
    logic               last;
    logic               gnt_id, gnt_valid;
    logic               issue_done, rsp_done;

    // Reset gates the grant so REQ_READY stays low on a reset edge.
    rr_arb2 u_arb (
        .valid     (bus.REQ_VALID),
        .last      (last),
        .enable    ((state_q == IDLE) && RST),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last = 1'b1;
`else
    logic last_q;
    always_ff @(posedge CLK) begin
        if (!RST)          last_q <= 1'b1;
        else if (gnt_valid) last_q <= gnt_id;
    end
    assign last = last_q;
`endif

    // First ISSUE cycle launches operands into the registered ALU; the counter
    // then runs ALU_LAT-1..0 so ALU_OUT is sampled ALU_LAT+1 edges after accept.
    assign issue_done = (state_q == ISSUE) && launch_q && (cnt_q == '0);
    assign rsp_done   = (state_q == RESP) && bus.RSP_READY[gid_q];

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid)  state_d = ISSUE;
            ISSUE:   if (issue_done) state_d = RESP;
            RESP:    if (rsp_done)   state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q    <= '0;
            launch_q <= 1'b0;
            gid_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            rsp_q    <= '0;
        end else if (gnt_valid) begin
            cnt_q    <= CNT_W'(ALU_LAT - 1);
            launch_q <= 1'b0;
            gid_q    <= gnt_id;
            opa_q    <= gnt_id ? bus.REQ_A[7:4]  : bus.REQ_A[3:0];
            opb_q    <= gnt_id ? bus.REQ_B[7:4]  : bus.REQ_B[3:0];
            op_q     <= gnt_id ? bus.REQ_OP[3:2] : bus.REQ_OP[1:0];
        end else if (state_q == ISSUE) begin
            if (!launch_q)          launch_q <= 1'b1;
            else if (cnt_q != '0)   cnt_q    <= cnt_q - 2'd1;
            if (issue_done)         rsp_q    <= bus.ALU_OUT;
        end
    end

    always_comb begin
        bus.REQ_READY = gnt_valid ? (2'b01 << gnt_id) : 2'b00;
        bus.RSP_VALID = (state_q == RESP) ? (2'b01 << gid_q) : 2'b00;
        bus.RSP_OUT   = rsp_q;
        bus.BUSY      = (state_q != IDLE);
        bus.GRANT_ID  = gid_q;
        bus.ALU_A     = '0;
        bus.ALU_B     = '0;
        bus.ALU_OP    = '0;
        if (state_q == ISSUE) begin
            bus.ALU_A  = opa_q;
            bus.ALU_B  = opb_q;
            bus.ALU_OP = op_q;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter (ALU_LAT=1 and ALU_LAT=3 instances).
// Stimulus pushes hand-computed results; monitors pop on each response handshake.
module tb_alu_arbiter;

    typedef struct {
        int gid;
        int res;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    alu_arbiter_if bus1 ();
    alu_arbiter_if bus3 ();

    alu_arbiter #(.ALU_LAT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));
    alu_arbiter #(.ALU_LAT(3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3.slave));

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc1 = 0, hs_cyc1 = 0, acc_cyc3 = 0;
    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1, e3;
    logic [1:0] prev_v1 = 2'b00, prev_v3 = 2'b00;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] stub(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        case (op)
            2'b00:   return sa + sb;
            2'b01:   return sa - sb;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge CLK) bus1.ALU_OUT <= stub(bus1.ALU_OP, bus1.ALU_A, bus1.ALU_B);
    always @(posedge CLK) bus3.ALU_OUT <= stub(bus3.ALU_OP, bus3.ALU_A, bus3.ALU_B);

    task automatic chk(input string nm, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Response monitors
    always @(negedge CLK) begin
        if (RST) begin
            if (bus1.RSP_VALID != 2'b00 && prev_v1 == 2'b00) chk("lat1", cyc - acc_cyc1, 2);
            if ((bus1.RSP_VALID & bus1.RSP_READY) != 2'b00) begin
                hs_cyc1 = cyc + 1;
                if (sb1.size() == 0) chk("sb1_extra", 1, 0);
                else begin
                    e1 = sb1.pop_front();
                    chk("own1", bus1.RSP_VALID, 1 << e1.gid);
                    chk("gid1", bus1.GRANT_ID, e1.gid);
                    chk("res1", $signed(bus1.RSP_OUT), e1.res);
                end
            end
        end
        prev_v1 = bus1.RSP_VALID;
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (bus3.RSP_VALID != 2'b00 && prev_v3 == 2'b00) chk("lat3", cyc - acc_cyc3, 4);
            if ((bus3.RSP_VALID & bus3.RSP_READY) != 2'b00) begin
                if (sb3.size() == 0) chk("sb3_extra", 1, 0);
                else begin
                    e3 = sb3.pop_front();
                    chk("own3", bus3.RSP_VALID, 1 << e3.gid);
                    chk("res3", $signed(bus3.RSP_OUT), e3.res);
                end
            end
        end
        prev_v3 = bus3.RSP_VALID;
    end

    task automatic set_req(input int idx, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b);
        if (idx == 0) begin
            bus1.REQ_OP[1:0] = op; bus1.REQ_A[3:0] = a; bus1.REQ_B[3:0] = b;
            bus1.REQ_VALID[0] = 1'b1;
        end else begin
            bus1.REQ_OP[3:2] = op; bus1.REQ_A[7:4] = a; bus1.REQ_B[7:4] = b;
            bus1.REQ_VALID[1] = 1'b1;
        end
    endtask

    // Waits for an accept on bus1; returns just after the accepting edge.
    task automatic wait_any(output int who);
        int n = 0;
        who = -1;
        @(negedge CLK);
        while ((bus1.REQ_VALID & bus1.REQ_READY) == 2'b00 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        else begin
            who = bus1.REQ_READY[1] ? 1 : 0;
            acc_cyc1 = cyc + 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb1.size() != 0 || sb3.size() != 0 || bus1.BUSY || bus3.BUSY) && n < 100) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 1, 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        bus1.REQ_VALID = 2'b00;
        bus3.REQ_VALID = 2'b00;
        RST = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, bus1.REQ_READY, 0);
        chk({tag, "_rsp_valid"}, bus1.RSP_VALID, 0);
        chk({tag, "_rsp_out"},   bus1.RSP_OUT, 0);
        chk({tag, "_alu_a"},     bus1.ALU_A, 0);
        chk({tag, "_alu_b"},     bus1.ALU_B, 0);
        chk({tag, "_alu_op"},    bus1.ALU_OP, 0);
        chk({tag, "_busy"},      bus1.BUSY, 0);
        chk({tag, "_grant_id"},  bus1.GRANT_ID, 0);
        chk({tag, "_busy3"},     bus3.BUSY, 0);
        chk({tag, "_rsp_valid3"}, bus3.RSP_VALID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int who;
        int exp_seq[4];
        exp_t ex;

        // Reset with requests pending: no READY, all outputs 0.
        bus1.REQ_VALID = 2'b11; bus1.REQ_A = '0; bus1.REQ_B = '0; bus1.REQ_OP = '0;
        bus1.RSP_READY = 2'b11;
        bus3.REQ_VALID = 2'b11; bus3.REQ_A = '0; bus3.REQ_B = '0; bus3.REQ_OP = '0;
        bus3.RSP_READY = 2'b11;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_outputs_zero("reset");
        @(posedge CLK);
        #1;
        bus1.REQ_VALID = 2'b00;
        bus3.REQ_VALID = 2'b00;
        RST = 1'b1;

        // Requester 0 alone: 3 + 2 = 5
        ex = '{gid: 0, res: 5}; sb1.push_back(ex);
        set_req(0, 2'b00, 4'd3, 4'd2);
        wait_any(who);
        chk("solo_who", who, 0);
        bus1.REQ_VALID = 2'b00;
        drain();

        // Contention from reset: r0 (-8 - 1 = -9) first, then r1 (7 + 7 = 14)
        do_reset();
        ex = '{gid: 0, res: -9}; sb1.push_back(ex);
        ex = '{gid: 1, res: 14}; sb1.push_back(ex);
        set_req(0, 2'b01, 4'h8, 4'd1);
        set_req(1, 2'b00, 4'd7, 4'd7);
        wait_any(who);
        chk("cont_first", who, 0);
        bus1.REQ_VALID[0] = 1'b0;
        wait_any(who);
        chk("cont_second", who, 1);
        bus1.REQ_VALID[1] = 1'b0;
        drain();

        // Both held valid for 4 transactions: r0 1+1=2, r1 2-(-3)=5
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            ex.gid = exp_seq[k];
            ex.res = (exp_seq[k] == 0) ? 2 : 5;
            sb1.push_back(ex);
        end
        set_req(0, 2'b00, 4'd1, 4'd1);
        set_req(1, 2'b01, 4'd2, 4'hD);
        for (int k = 0; k < 4; k++) begin
            wait_any(who);
            chk($sformatf("alt_grant%0d", k), who, exp_seq[k]);
        end
        bus1.REQ_VALID = 2'b00;
        drain();

        // Response held: non-owner READY high only; r0 -1 + -2 = -3; r1 0 - 5 = -5 waits
        bus1.RSP_READY = 2'b10;
        ex = '{gid: 0, res: -3}; sb1.push_back(ex);
        set_req(0, 2'b00, 4'hF, 4'hE);
        wait_any(who);
        bus1.REQ_VALID[0] = 1'b0;
        ex = '{gid: 1, res: -5}; sb1.push_back(ex);
        set_req(1, 2'b01, 4'd0, 4'd5);
        begin
            int n = 0;
            while (bus1.RSP_VALID == 2'b00 && n < 20) begin
                @(posedge CLK);
                #1;
                n++;
            end
            if (n >= 20) chk("hold_rsp_timeout", 1, 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("hold_valid", bus1.RSP_VALID, 1);
            chk("hold_out", $signed(bus1.RSP_OUT), -3);
            chk("hold_busy", bus1.BUSY, 1);
            chk("hold_req_ready", bus1.REQ_READY, 0);
        end
        @(posedge CLK);
        #1;
        bus1.RSP_READY = 2'b11;
        wait_any(who);
        chk("after_hold_who", who, 1);
        chk("idle_gap", acc_cyc1 - hs_cyc1, 1);
        bus1.REQ_VALID[1] = 1'b0;
        drain();

        // Reset during ISSUE aborts; then a fresh r0 5 - (-3) = 8 completes
        set_req(1, 2'b00, 4'd1, 4'd1);
        wait_any(who);
        bus1.REQ_VALID = 2'b00;
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk_outputs_zero("abort");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("abort_no_rsp", bus1.RSP_VALID, 0);
        end
        @(posedge CLK);
        #1;
        ex = '{gid: 0, res: 8}; sb1.push_back(ex);
        set_req(0, 2'b01, 4'd5, 4'hD);
        wait_any(who);
        chk("fresh_who", who, 0);
        bus1.REQ_VALID = 2'b00;
        drain();

        // ALU_LAT=3 instance: 3 + 4 = 7, operands stable through ISSUE
        ex = '{gid: 0, res: 7}; sb3.push_back(ex);
        bus3.REQ_OP[1:0] = 2'b00; bus3.REQ_A[3:0] = 4'd3; bus3.REQ_B[3:0] = 4'd4;
        bus3.REQ_VALID[0] = 1'b1;
        begin
            int n = 0;
            @(negedge CLK);
            while (!(bus3.REQ_VALID[0] && bus3.REQ_READY[0]) && n < 50) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 50) chk("accept3_timeout", 1, 0);
            acc_cyc3 = cyc + 1;
        end
        @(posedge CLK);
        #1;
        bus3.REQ_VALID = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("lat3_alu_a", bus3.ALU_A, 3);
            chk("lat3_alu_b", bus3.ALU_B, 4);
            chk("lat3_alu_op", bus3.ALU_OP, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1: ALU result latency in clock edges; legal range 1..4.
REQ-002 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port RST, input, 1: reset, synchronous, active-low.
REQ-004 Port REQ_VALID, input, 2: per-requester operation request; bit i belongs to requester i.
REQ-005 Port REQ_READY, output, 2: per-requester accept; a request transfers on an edge where VALID and READY are both high.
REQ-006 Port REQ_A, input, 8: packed signed 4-bit A operands; [3:0] is requester 0, [7:4] is requester 1.
REQ-007 Port REQ_B, input, 8: packed signed 4-bit B operands, same packing as REQ_A.
REQ-008 Port REQ_OP, input, 4: packed 2-bit opcodes; [1:0] is requester 0, [3:2] is requester 1.
REQ-009 Port RSP_VALID, output, 2: result valid, asserted only for the requester that owns the transaction.
REQ-010 Port RSP_READY, input, 2: per-requester result consume.
REQ-011 Port RSP_OUT, output, 8: signed result, shared by both requesters.
REQ-012 Port ALU_A / ALU_B, output, 4 each: signed operands driven to the shared ALU.
REQ-013 Port ALU_OP, output, 2: opcode driven to the shared ALU.
REQ-014 Port ALU_OUT, input, 8: signed ALU result.
REQ-015 Port BUSY, output, 1: high in any state other than IDLE.
REQ-016 Port GRANT_ID, output, 1: index of the requester that owns the current transaction.

Function
REQ-017 The FSM SHALL have three states:
- IDLE -> ISSUE on an accepted request.
- ISSUE -> RESP after ALU_LAT cycles.
- RESP -> IDLE on RSP_VALID & RSP_READY for the owner.
REQ-018 In IDLE, REQ_READY SHALL be high only for the granted requester, and only while that requester's REQ_VALID is high; REQ_READY SHALL be 0 in ISSUE and RESP.
REQ-019 Without the macro in REQ-029, arbitration SHALL be round-robin:
- a sole valid requester wins;
- when both are valid, the requester not served last wins;
- the last-served pointer resets to 1, so requester 0 wins the first contention.
REQ-020 On acceptance, the arbiter SHALL register the winner's A, B and OP and drive them on ALU_A, ALU_B and ALU_OP, held stable throughout ISSUE.
REQ-021 A latency counter SHALL load ALU_LAT-1 on acceptance, and ALU_OUT SHALL be captured into RSP_OUT on the edge where the counter is 0 in ISSUE.
REQ-022 RSP_VALID SHALL rise exactly ALU_LAT+1 edges after the accepting edge.
REQ-023 RSP_VALID and RSP_OUT SHALL hold until the owner's RSP_READY is high; RSP_READY of the non-owner SHALL be ignored.
REQ-024 The earliest next acceptance SHALL be the edge after the response handshake, i.e. one idle cycle between transactions.
REQ-025 Outside ISSUE, ALU_A, ALU_B and ALU_OP SHALL be driven to 0.
REQ-026 RSP_OUT SHALL be passed through from ALU_OUT unmodified; the arbiter performs no arithmetic on it.
REQ-027 A request withdrawn before acceptance SHALL be dropped silently, and a request arriving during ISSUE or RESP SHALL wait.

Reset
REQ-028 While RST=0 at a clock edge:
- state SHALL return to IDLE;
- the counter SHALL clear to 0;
- the last-served pointer SHALL be set to 1;
- REQ_READY, RSP_VALID, RSP_OUT, ALU_A, ALU_B, ALU_OP, BUSY and GRANT_ID SHALL all be 0;
- an in-flight transaction SHALL be aborted and its result discarded.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN:
- defined: requester 0 SHALL always win contention, and the pointer logic is compiled out;
- undefined: the round-robin arbitration of REQ-019 applies.

Structure
REQ-030 Package alu_arb_pkg SHALL hold:
- width constants OPND_W=4, OP_W=2, RES_W=8, NREQ=2;
- the state enum {IDLE, ISSUE, RESP}.
REQ-031 The grant logic SHALL be one sub-module, rr_arb2, with inputs valid[1:0], last and enable, and output grant id plus a grant-valid signal.

Verification
REQ-032 The bench SHALL use ALU_LAT=1 and a stub ALU that registers ALU_OUT = sext(A)+sext(B) for OP 00 and sext(A)-sext(B) for OP 01, and SHALL cover:
- Requester 0 alone, OP=00, A=3, B=2 -> RSP_VALID[0] rises 2 edges after acceptance, RSP_OUT=8'sd5, GRANT_ID=0.
- Both requesters valid from reset: r0 OP=01 A=-8 B=1, r1 OP=00 A=7 B=7 -> r0 is served first (RSP_OUT=-9), then r1 (RSP_OUT=14).
- Both requesters held valid for 4 transactions -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN defined, grants are 0,0,0,0.
- RSP_READY held low for 5 cycles -> RSP_VALID and RSP_OUT stay stable, BUSY=1, no new REQ_READY.
- RST=0 asserted during ISSUE -> next cycle all outputs are 0, no RSP_VALID follows, and a fresh request completes normally.
- Rerun with ALU_LAT=3 -> RSP_VALID rises 4 edges after acceptance, and ALU operands are held stable for 3 cycles.
